// File: rtl/read_prefetch_block.sv
// First-word-fall-through prefetch adapter: pops a registered-read FIFO and
// presents its words on a valid/ready stream through a 2-entry output buffer.
module read_prefetch_block #(
    parameter int unsigned data_size = 8
) (
    input  logic                 read_clock_i,
    input  logic                 read_reset_n_i,
    input  logic                 read_empty_i,
    input  logic [data_size-1:0] read_data_i,
    output logic                 read_inc_o,
    input  logic                 ready_i,
    input  logic                 flush_i,
    output logic [data_size-1:0] data_o,
    output logic                 valid_o,
    output logic                 last_o,
    output logic [1:0]           count_o
);
    localparam int unsigned CNT_W = 2;
    localparam int unsigned SUM_W = 3;

    logic [data_size-1:0] buf0_q, buf0_d;
    logic [data_size-1:0] buf1_q, buf1_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 inflight_q, inflight_d;

    logic                 take;
    logic                 drop;
    logic                 arrive;
    logic [SUM_W-1:0]     pending;
    logic [CNT_W-1:0]     count_pt;

    // Pop control, shift-then-write buffer update and occupancy.
    always_comb begin
        take       = valid_o & ready_i & ~flush_i;
        // Pops are gated while flushing, so the only word that can need
        // discarding is the one landing in the flush cycle itself.
        drop       = flush_i & inflight_q;
        arrive     = inflight_q & ~drop;
        pending    = SUM_W'(count_q) + SUM_W'(inflight_q) - SUM_W'(take);
        read_inc_o = ~read_empty_i & ~flush_i & (pending < SUM_W'(2));
        inflight_d = read_inc_o;

        count_pt   = count_q - CNT_W'(take);
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        if (take) begin
            buf0_d = buf1_q;
        end
        if (arrive) begin
            if (count_pt == CNT_W'(0)) begin
                buf0_d = read_data_i;
            end else begin
                buf1_d = read_data_i;
            end
        end

        if (flush_i) begin
            count_d = CNT_W'(0);
        end else begin
            count_d = count_pt + CNT_W'(arrive);
        end
    end

    always_ff @(posedge read_clock_i or negedge read_reset_n_i) begin
        if (!read_reset_n_i) begin
            buf0_q     <= '0;
            buf1_q     <= '0;
            count_q    <= CNT_W'(0);
            inflight_q <= 1'b0;
        end else begin
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    assign valid_o = (count_q != CNT_W'(0));
    assign data_o  = buf0_q;
    assign count_o = count_q;
    assign last_o  = valid_o & (count_q == CNT_W'(1)) & ~inflight_q & read_empty_i;

    // Buffered plus in-flight words never exceed the buffer depth.
    a_no_overflow: assert property (@(posedge read_clock_i) disable iff (!read_reset_n_i)
        (SUM_W'(count_q) + SUM_W'(inflight_q) <= SUM_W'(2)));

endmodule

// File: tb/tb_read_prefetch_block.sv
// Directed bench for read_prefetch_block with a registered-read FIFO model
// and an in-order scoreboard on every accepted word.
module tb_read_prefetch_block;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          read_empty;
    logic [DW-1:0] read_data;
    logic          read_inc;
    logic          ready = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] data;
    logic          valid;
    logic          last;
    logic [1:0]    count;

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int held   = 0;
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    read_prefetch_block #(.data_size(DW)) dut (
        .read_clock_i   (clk),
        .read_reset_n_i (rst_n),
        .read_empty_i   (read_empty),
        .read_data_i    (read_data),
        .read_inc_o     (read_inc),
        .ready_i        (ready),
        .flush_i        (flush),
        .data_o         (data),
        .valid_o        (valid),
        .last_o         (last),
        .count_o        (count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Registered-read FIFO: data follows a pop by one cycle, empty is registered.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_empty <= 1'b1;
            read_data  <= '0;
        end else begin
            if (read_inc && fifo_q.size() > 0) begin
                read_data <= fifo_q.pop_front();
            end
            read_empty <= (fifo_q.size() == 0);
        end
    end

    // Scoreboard on accepted words plus outstanding-word bound.
    always @(negedge clk) begin
        logic tk;
        if (!rst_n) begin
            held = 0;
        end else begin
            tk = valid & ready & ~flush;
            if (read_inc) pops++;
            check_eq("outstanding_le2", 32'(held > 2), 32'(0));
            if (tk) begin
                if (exp_q.size() == 0) check_eq("sb_underflow", 32'(1), 32'(0));
                else check_eq("sb_data", 32'(data), 32'(exp_q.pop_front()));
            end
            if (flush) held = 0;
            else held = held + int'(read_inc) - int'(tk);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        step();
        @(negedge clk);
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        @(negedge clk);
        for (int i = 0; i < max_cyc && !valid; i++) cyc();
        check_eq(tag, 32'(valid), 32'(1));
    endtask

    task automatic wait_count2(input string tag);
        @(negedge clk);
        for (int i = 0; i < 12 && count != 2'd2; i++) cyc();
        check_eq(tag, 32'(count), 32'(2));
    endtask

    task automatic drain(input string tag);
        ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!valid && exp_q.size() == 0 && fifo_q.size() == 0 && read_empty) break;
        end
        check_eq({tag, "_left"}, 32'(exp_q.size()), 32'(0));
        check_eq({tag, "_idle"}, 32'(valid), 32'(0));
    endtask

    initial begin
        int base;
        int pushed;
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int pushed;

        // Reset values
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_count", 32'(count), 32'(0));
        check_eq("rst_valid", 32'(valid), 32'(0));
        check_eq("rst_last", 32'(last), 32'(0));
        check_eq("rst_data", 32'(data), 32'(0));
        check_eq("rst_inc", 32'(read_inc), 32'(0));
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Single word: pop once, valid two cycles after empty falls, flagged last
        base  = pops;
        ready = 1'b1;
        push(8'hA5);
        @(negedge clk);
        check_eq("sw_inc_early", 32'(read_inc), 32'(0));
        cyc();
        check_eq("sw_inc", 32'(read_inc), 32'(1));
        check_eq("sw_valid_t", 32'(valid), 32'(0));
        cyc();
        check_eq("sw_inc_once", 32'(read_inc), 32'(0));
        check_eq("sw_valid_t1", 32'(valid), 32'(0));
        cyc();
        check_eq("sw_valid_t2", 32'(valid), 32'(1));
        check_eq("sw_data", 32'(data), 32'(8'hA5));
        check_eq("sw_last", 32'(last), 32'(1));
        cyc();
        check_eq("sw_count_after", 32'(count), 32'(0));
        step();
        check_eq("sw_pops", 32'(pops - base), 32'(1));

        // Stream of 8 consecutive words, last only on the final one
        for (int i = 0; i < 8; i++) push(8'(i));
        wait_valid("st_start", 10);
        for (int i = 0; i < 8; i++) begin
            check_eq("st_valid", 32'(valid), 32'(1));
            check_eq("st_data", 32'(data), 32'(i));
            check_eq("st_last", 32'(last), 32'(i == 7));
            cyc();
        end
        check_eq("st_end_valid", 32'(valid), 32'(0));

        // Backpressure: two pops, head held, then drain in order
        step();
        ready = 1'b0;
        base  = pops;
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        repeat (10) cyc();
        check_eq("bp_count", 32'(count), 32'(2));
        check_eq("bp_data", 32'(data), 32'(8'h10));
        check_eq("bp_valid", 32'(valid), 32'(1));
        check_eq("bp_inc_low", 32'(read_inc), 32'(0));
        check_eq("bp_last", 32'(last), 32'(0));
        step();
        check_eq("bp_pops", 32'(pops - base), 32'(2));
        drain("bp");

        // Random ready with random writes of 200 words
        pushed = 0;
        for (int i = 0; i < 4000 && pushed < 200; i++) begin
            step();
            ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                push(8'($urandom));
                pushed++;
            end
        end
        check_eq("rnd_pushed", 32'(pushed), 32'(200));
        drain("rnd");

        // Flush with one buffered word and one in flight
        step();
        ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h30 + i));
        wait_count2("fl_fill");
        step();
        ready = 1'b1;
        @(negedge clk);
        step();
        ready = 1'b0;
        flush = 1'b1;
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge clk);
        check_eq("fl_count_in", 32'(count), 32'(1));
        check_eq("fl_inc_gated", 32'(read_inc), 32'(0));
        step();
        flush = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        check_eq("fl_count", 32'(count), 32'(0));
        check_eq("fl_valid", 32'(valid), 32'(0));
        wait_valid("fl_resume", 10);
        check_eq("fl_next_word", 32'(data), 32'(8'h33));
        drain("fl");

        // Asynchronous reset with a full buffer
        step();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        wait_count2("ar_fill");
        step();
        #2;
        rst_n = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        #1;
        check_eq("ar_count", 32'(count), 32'(0));
        check_eq("ar_valid", 32'(valid), 32'(0));
        check_eq("ar_last", 32'(last), 32'(0));
        check_eq("ar_data", 32'(data), 32'(0));
        check_eq("ar_inc", 32'(read_inc), 32'(0));
        repeat (2) step();
        rst_n = 1'b1;
        base = pops;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check_eq("ar_quiet", 32'(valid), 32'(0));
        end
        step();
        check_eq("ar_no_pops", 32'(pops - base), 32'(0));
        ready = 1'b1;
        push(8'h5A);
        wait_valid("ar_new", 10);
        check_eq("ar_new_data", 32'(data), 32'(8'h5A));
        drain("ar");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
